prod_accum_serializer: RTL and testbench



---
 rtl/prod_accum_serializer.sv | 112 +++++++++++
 tb/tb_prod_accum_serializer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum_serializer.sv
// Accumulates blocks of COUNT 8-bit products and streams each sum LSB byte first.
// Define PROD_ACCUM_SATURATE_EN to saturate the sum instead of wrapping.
module prod_accum_serializer #(
  parameter int COUNT = 4,
  parameter int ACC_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_prod,
  output logic       in_ready,
  input  logic       flush,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       ovf
);

  localparam int NBYTES = ACC_W / 8;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {
    ACCUM,
    SEND
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sh;
  logic [7:0]       cnt;
  logic [IW-1:0]    byte_idx;
  logic             acc_ovf;
  logic             ovf_flag;

  logic             accept;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] nxt;
  logic             go;
  logic [ACC_W-1:0] blk_sum;
  logic             blk_ovf;
  logic             is_last;

  // next-sum arithmetic and block-close decision
  always_comb begin
    accept = in_valid && (state == ACCUM);
    sum    = {1'b0, acc} + {{(ACC_W-7){1'b0}}, in_prod};
    carry  = sum[ACC_W];
`ifdef PROD_ACCUM_SATURATE_EN
    nxt    = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    nxt    = sum[ACC_W-1:0];
`endif
    go     = (state == ACCUM) &&
             ((accept && (cnt == 8'(COUNT-1))) ||
              (flush && ((cnt != 8'd0) || accept)));
    blk_sum = accept ? nxt : acc;
    blk_ovf = acc_ovf | (accept & carry);
    is_last = (byte_idx == IW'(NBYTES-1));
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == SEND);
  assign out_data  = sh[7:0];
  assign out_last  = (state == SEND) && is_last;
  assign ovf       = ovf_flag;

  // block FSM: accumulate, then shift the sum out byte by byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      sh       <= '0;
      cnt      <= '0;
      byte_idx <= '0;
      acc_ovf  <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (go) begin
            sh       <= blk_sum;
            ovf_flag <= blk_ovf;
            acc      <= '0;
            cnt      <= '0;
            acc_ovf  <= 1'b0;
            state    <= SEND;
          end else if (accept) begin
            acc     <= nxt;
            cnt     <= cnt + 8'd1;
            acc_ovf <= acc_ovf | carry;
          end
        end
        SEND: begin
          if (out_ready) begin
            sh <= sh >> 8;
            if (is_last) begin
              byte_idx <= '0;
              ovf_flag <= 1'b0;
              state    <= ACCUM;
            end else begin
              byte_idx <= byte_idx + IW'(1);
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum_serializer.sv
// Randomized + directed bench for prod_accum_serializer.
// Reference model works on whole blocks: sum of products, then bytes.
module tb_prod_accum_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, flush, out_ready;
  logic [7:0] in_prod;
  logic       in_ready, out_valid, out_last, ovf;
  logic [7:0] out_data;

  logic       b_in_valid, b_flush, b_out_ready;
  logic [7:0] b_prod;
  logic       b_in_ready, b_out_valid, b_out_last, b_ovf;
  logic [7:0] b_out_data;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       o;
  } exp_t;

  exp_t expq[$];
  bit   mon_on = 1'b1;
  logic pv, pr;
  logic [7:0] pd;

  always #5 clk = ~clk;

  prod_accum_serializer #(.COUNT(4), .ACC_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_prod(in_prod), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .ovf(ovf)
  );

  prod_accum_serializer #(.COUNT(2), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_prod(b_prod), .in_ready(b_in_ready),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
    .out_ready(b_out_ready), .ovf(b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: sum the block with plain integers, then split into bytes
  task automatic push_block(input int prods[$], input int acc_w);
    longint s = 0;
    longint mx = (longint'(1) << acc_w) - 1;
    bit o = 1'b0;
    foreach (prods[i]) begin
      s = s + prods[i];
      if (s > mx) begin
        o = 1'b1;
`ifdef PROD_ACCUM_SATURATE_EN
        s = mx;
`else
        s = s - (mx + 1);
`endif
      end
    end
    for (int i = 0; i < acc_w / 8; i++) begin
      exp_t e;
      e.d = 8'((s >> (8 * i)) & 255);
      e.l = (i == acc_w / 8 - 1);
      e.o = o;
      expq.push_back(e);
    end
  endtask

  // stream monitor: every handshake must match the next model byte
  always @(negedge clk) begin
    if (!rst && mon_on) begin
      if (pv && !pr) chk("hold_data", out_data, pd);
      if (pv && !pr) chk("hold_valid", out_valid, 1);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("extra_byte", out_data, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("byte", out_data, e.d);
          chk("last", out_last, e.l);
          chk("ovf", ovf, e.o);
        end
      end
    end
    pv = out_valid && !rst;
    pr = out_ready;
    pd = out_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
  endtask

  task automatic send_prod(input logic [7:0] p, input logic fl);
    wait_rdy();
    in_valid = 1'b1;
    in_prod  = p;
    flush    = fl;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_flush();
    wait_rdy();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 500) begin
      step();
      n++;
    end
    chk("drain", expq.size(), 0);
  endtask

  initial begin
    int q[$];
    bit rand_on;
    rst = 1'b1;
    in_valid = 0; flush = 0; out_ready = 0; in_prod = 0;
    b_in_valid = 0; b_flush = 0; b_out_ready = 0; b_prod = 0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    // basic block, back-to-back, always ready
    out_ready = 1'b1;
    q = '{9, 'hE1, 'h10, 1};
    push_block(q, 16);
    foreach (q[i]) begin
      in_valid = 1'b1;
      in_prod  = 8'(q[i]);
      step();
    end
    in_valid = 1'b0;
    chk("lat_out_valid", out_valid, 1);
    chk("busy0_in_ready", in_ready, 0);
    step();
    chk("busy1_in_ready", in_ready, 0);
    step();
    chk("back_in_ready", in_ready, 1);
    drain();

    // partial block closed by a lone flush
    q = '{'h40, 'h40};
    send_prod(8'h40, 1'b0);
    send_prod(8'h40, 1'b0);
    push_block(q, 16);
    send_flush();
    drain();
    send_flush();
    for (int i = 0; i < 3; i++) begin
      chk("empty_flush", out_valid, 0);
      step();
    end

    // back-pressure: sum held while downstream stalls
    out_ready = 1'b0;
    q = '{5, 5, 5, 5};
    foreach (q[i]) send_prod(8'(q[i]), 1'b0);
    push_block(q, 16);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h14);
      chk("stall_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_prod  = 8'hAA;
      flush    = 1'b1;
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
    drain();

    // narrow accumulator overflow
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_prod      = 8'hFF;
    step();
    b_prod = 8'h02;
    step();
    b_in_valid = 1'b0;
    begin
      int bq[$];
      exp_t e;
      bq = '{'hFF, 2};
      mon_on = 1'b0;
      push_block(bq, 8);
      e = expq.pop_front();
      mon_on = 1'b1;
      chk("w8_valid", b_out_valid, 1);
      chk("w8_data", b_out_data, e.d);
      chk("w8_last", b_out_last, e.l);
      chk("w8_ovf", b_ovf, e.o);
    end
    step();
    chk("w8_done", b_out_valid, 0);

    // reset mid-transmission discards the rest of the block
    out_ready = 1'b0;
    q = '{'h11, 'h22, 'h33, 'h44};
    foreach (q[i]) send_prod(8'(q[i]), 1'b0);
    push_block(q, 16);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    expq.delete();
    chk("rst_send_valid", out_valid, 0);
    chk("rst_send_ready", in_ready, 1);
    out_ready = 1'b1;
    q = '{1, 1, 1, 1};
    foreach (q[i]) send_prod(8'(q[i]), 1'b0);
    push_block(q, 16);
    drain();

    // flush coinciding with an accepted product
    q = '{3, 7};
    send_prod(8'h03, 1'b0);
    push_block(q, 16);
    send_prod(8'h07, 1'b1);
    drain();
    q = '{1, 1, 1};
    foreach (q[i]) send_prod(8'(q[i]), 1'b0);
    chk("cnt_restart", out_valid, 0);
    q.push_back(1);
    push_block(q, 16);
    send_prod(8'h01, 1'b0);
    drain();

    // random blocks with random downstream stalls
    rand_on = 1'b1;
    fork
      begin
        for (int b = 0; b < 30; b++) begin
          int n = $urandom_range(1, 4);
          int mode = $urandom_range(0, 1);
          q.delete();
          for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 255));
          for (int i = 0; i < n; i++) begin
            bit fl = (i == n - 1) && (n < 4) && (mode == 0);
            send_prod(8'(q[i]), fl);
            if (i == n - 1 && (n == 4 || mode == 0)) push_block(q, 16);
          end
          if (n < 4 && mode == 1) begin
            push_block(q, 16);
            send_flush();
          end
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          step();
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
